// File: rtl/vga_sync_receiver.sv
// Receiving-end monitor for a VGA-style sync + RGB stream: recovers pixel
// coordinates, checks line/frame timing, tracks lock and a per-frame checksum.
module vga_sync_receiver #(
  parameter int WIDTH           = 640,
  parameter int HEIGHT          = 480,
  parameter int H_TOTAL         = 800,
  parameter int V_TOTAL         = 525,
  parameter int H_START         = 144,
  parameter int V_START         = 35,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic        hSync,
  input  logic        vSync,
  input  logic [11:0] rgb_in,
  output logic [9:0]  x,
  output logic [8:0]  y,
  output logic        pix_valid,
  output logic [11:0] rgb_out,
  output logic        frame_start,
  output logic        locked,
  output logic        timing_err,
  output logic [7:0]  err_count,
  output logic [15:0] frame_sum,
  output logic        sum_valid
);

  localparam logic        SYNC_IDLE = SYNC_ACTIVE_LOW;
  localparam logic [10:0] H_LO      = 11'(H_START);
  localparam logic [10:0] H_HI      = 11'(H_START + WIDTH);
  localparam logic [10:0] V_LO      = 11'(V_START);
  localparam logic [10:0] V_HI      = 11'(V_START + HEIGHT);
  localparam logic [10:0] H_TOT     = 11'(H_TOTAL);
  localparam logic [10:0] V_TOT     = 11'(V_TOTAL);
  localparam logic [9:0]  H_OFF     = 10'(H_START);
  localparam logic [9:0]  V_OFF     = 10'(V_START);
  localparam logic [9:0]  CNT_MAX   = 10'h3FF;

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  // Input pipeline: two ungated flops on every pin so syncs and colour stay aligned.
  logic [1:0]  hs_pipe_q, vs_pipe_q;
  logic [11:0] rgb_s1_q, rgb_s2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_pipe_q <= {SYNC_IDLE, SYNC_IDLE};
      vs_pipe_q <= {SYNC_IDLE, SYNC_IDLE};
      rgb_s1_q  <= '0;
      rgb_s2_q  <= '0;
    end else begin
      hs_pipe_q <= {hs_pipe_q[0], hSync};
      vs_pipe_q <= {vs_pipe_q[0], vSync};
      rgb_s1_q  <= rgb_in;
      rgb_s2_q  <= rgb_s1_q;
    end
  end

  logic hs_act, vs_act;
  logic hs_prev_q, vs_prev_q;
  logic h_edge, v_edge;

  assign hs_act = hs_pipe_q[1] ^ SYNC_ACTIVE_LOW;
  assign vs_act = vs_pipe_q[1] ^ SYNC_ACTIVE_LOW;
  assign h_edge = pix_en & hs_act & ~hs_prev_q;
  assign v_edge = pix_en & vs_act & ~vs_prev_q;

  // hcnt_d/vcnt_d index the current tick; the registered copies hold the previous tick.
  logic [9:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;

  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (pix_en) begin
      if (h_edge)
        hcnt_d = '0;
      else if (hcnt_q != CNT_MAX)
        hcnt_d = hcnt_q + 10'd1;
      if (v_edge)
        vcnt_d = '0;
      else if (h_edge && (vcnt_q != CNT_MAX))
        vcnt_d = vcnt_q + 10'd1;
    end
  end

  logic h_in, v_in, active;

  assign h_in   = ({1'b0, hcnt_d} >= H_LO) && ({1'b0, hcnt_d} < H_HI);
  assign v_in   = ({1'b0, vcnt_d} >= V_LO) && ({1'b0, vcnt_d} < V_HI);
  assign active = pix_en && h_in && v_in;

  state_t      state_q;
  logic        line_seen_q;
  logic        checking, line_bad, frame_bad, mismatch;

  // The first hsync edge after reset or a mismatch has no valid line behind it.
  assign checking  = (state_q != SEARCH);
  assign line_bad  = h_edge && checking && line_seen_q && (({1'b0, hcnt_q} + 11'd1) != H_TOT);
  assign frame_bad = v_edge && checking && (({1'b0, vcnt_q} + 11'd1) != V_TOT);
  assign mismatch  = line_bad || frame_bad;

  logic [9:0]  x_q;
  logic [8:0]  y_q;
  logic        pix_valid_q;
  logic [11:0] rgb_out_q;
  logic        frame_start_q;
  logic        locked_q;
  logic        timing_err_q;
  logic [7:0]  err_count_q;
  logic [15:0] acc_q;
  logic [15:0] frame_sum_q;
  logic        sum_valid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_prev_q     <= 1'b0;
      vs_prev_q     <= 1'b0;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      state_q       <= SEARCH;
      line_seen_q   <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      pix_valid_q   <= 1'b0;
      rgb_out_q     <= '0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      timing_err_q  <= 1'b0;
      err_count_q   <= '0;
      acc_q         <= '0;
      frame_sum_q   <= '0;
      sum_valid_q   <= 1'b0;
    end else begin
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      pix_valid_q   <= active;
      frame_start_q <= v_edge;
      timing_err_q  <= mismatch;
      sum_valid_q   <= 1'b0;

      if (pix_en) begin
        hs_prev_q <= hs_act;
        vs_prev_q <= vs_act;
      end

      if (active) begin
        x_q       <= hcnt_d - H_OFF;
        y_q       <= 9'(vcnt_d - V_OFF);
        rgb_out_q <= rgb_s2_q;
      end

      if (mismatch && (err_count_q != 8'hFF))
        err_count_q <= err_count_q + 8'd1;

      if (mismatch)
        line_seen_q <= 1'b0;
      else if (h_edge)
        line_seen_q <= 1'b1;

      unique case (state_q)
        SEARCH: begin
          locked_q <= 1'b0;
          if (v_edge)
            state_q <= TRACK;
        end
        TRACK: begin
          if (mismatch) begin
            state_q  <= SEARCH;
            locked_q <= 1'b0;
          end else if (v_edge) begin
            state_q  <= LOCKED;
            locked_q <= 1'b1;
          end else begin
            locked_q <= 1'b0;
          end
        end
        LOCKED: begin
          if (mismatch) begin
            state_q  <= SEARCH;
            locked_q <= 1'b0;
          end else begin
            locked_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= SEARCH;
          locked_q <= 1'b0;
        end
      endcase

      // Only a frame closed cleanly while locked is published.
      if (v_edge) begin
        if ((state_q == LOCKED) && !mismatch) begin
          frame_sum_q <= acc_q;
          sum_valid_q <= 1'b1;
        end
        acc_q <= '0;
      end else if (active) begin
        acc_q <= acc_q + {4'b0000, rgb_s2_q};
      end
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign pix_valid   = pix_valid_q;
  assign rgb_out     = rgb_out_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign timing_err  = timing_err_q;
  assign err_count   = err_count_q;
  assign frame_sum   = frame_sum_q;
  assign sum_valid   = sum_valid_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver using a scaled-down timing so whole
// frames fit in a short run: 16 ticks/line, 8 lines/frame, 8x4 active pixels.
module tb_vga_sync_receiver;

  localparam int WIDTH   = 8;
  localparam int HEIGHT  = 4;
  localparam int H_TOTAL = 16;
  localparam int V_TOTAL = 8;
  localparam int H_START = 5;
  localparam int V_START = 2;
  localparam int HSW     = 2;
  localparam int VSW     = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_en;
  logic        hSync;
  logic        vSync;
  logic [11:0] rgb_in;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        pix_valid;
  logic [11:0] rgb_out;
  logic        frame_start;
  logic        locked;
  logic        timing_err;
  logic [7:0]  err_count;
  logic [15:0] frame_sum;
  logic        sum_valid;

  vga_sync_receiver #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL),
    .H_START(H_START), .V_START(V_START), .SYNC_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .hSync(hSync), .vSync(vSync),
    .rgb_in(rgb_in), .x(x), .y(y), .pix_valid(pix_valid), .rgb_out(rgb_out),
    .frame_start(frame_start), .locked(locked), .timing_err(timing_err),
    .err_count(err_count), .frame_sum(frame_sum), .sum_valid(sum_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Observations gathered once per pixel tick.
  int align;
  int pv_cnt, pv_bad, xy_bad, rgb_bad, early_bad;
  int first_x, first_y, last_x, last_y;
  int terr_cnt, terr_line, terr_t, terr_fs;
  int fs_cnt, sv_cnt, fs_at_sv, rise_fs, wrap_seen;
  int prev_locked = 0;
  int prev_err    = 0;

  task automatic clear_stats();
    pv_cnt = 0; pv_bad = 0; xy_bad = 0; rgb_bad = 0; early_bad = 0;
    first_x = -1; first_y = -1; last_x = -1; last_y = -1;
    terr_cnt = 0; terr_line = -1; terr_t = -1; terr_fs = -1;
    fs_cnt = 0; sv_cnt = 0; fs_at_sv = -1; rise_fs = -1; wrap_seen = 0;
  endtask

  // One pixel tick: pins change at a negedge, pix_en is sampled on the third
  // posedge (when the pin value sits in stage 2), outputs read on the next negedge.
  task automatic tick(input logic hs_a, input logic vs_a, input logic [11:0] rgb,
                      input int act, input int line, input int t);
    hSync  = ~hs_a;
    vSync  = ~vs_a;
    rgb_in = rgb;
    pix_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    if (pix_valid !== 1'b0) early_bad++;
    pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
    if (align != 0 && pix_valid !== (act != 0)) pv_bad++;
    if (pix_valid === 1'b1) begin
      pv_cnt++;
      if (pv_cnt == 1) begin first_x = int'(x); first_y = int'(y); end
      last_x = int'(x);
      last_y = int'(y);
      if (align != 0 && (x !== 10'(t - H_START) || y !== 9'(line - V_START))) xy_bad++;
      if (rgb_out !== rgb) rgb_bad++;
    end
    if (frame_start === 1'b1) fs_cnt++;
    if (timing_err === 1'b1) begin
      terr_cnt++; terr_line = line; terr_t = t; terr_fs = fs_cnt;
    end
    if (sum_valid === 1'b1) begin sv_cnt++; fs_at_sv = fs_cnt; end
    if (locked === 1'b1 && prev_locked == 0) rise_fs = fs_cnt;
    prev_locked = (locked === 1'b1) ? 1 : 0;
    if (int'(err_count) < prev_err) wrap_seen++;
    prev_err = int'(err_count);
    @(negedge clk);
  endtask

  // mode 0: constant 12'h00F, mode 1: x[3:0], mode 2: 12'hFFF; blanking carries junk.
  task automatic drive_lines(input int l0, input int l1, input int bad_line,
                             input int bad_len, input int mode);
    for (int l = l0; l < l1; l++) begin
      int len;
      len = (l == bad_line) ? bad_len : H_TOTAL;
      for (int t = 0; t < len; t++) begin
        int act;
        logic [11:0] pix;
        act = (t >= H_START && t < H_START + WIDTH && l >= V_START && l < V_START + HEIGHT) ? 1 : 0;
        if (act == 0)       pix = 12'h5A5;
        else if (mode == 0) pix = 12'h00F;
        else if (mode == 1) pix = {8'h00, 4'(t - H_START)};
        else                pix = 12'hFFF;
        tick(t < HSW, l < VSW, pix, act, l, t);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; pix_en = 1'b0; hSync = 1'b1; vSync = 1'b1; rgb_in = 12'h000;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({x, y, rgb_out} !== 31'd0) begin
      n_fail++; $display("FAIL reset_xy_rgb: got x=%0d y=%0d rgb=%h want 0", x, y, rgb_out);
    end
    n_checks++;
    if ({pix_valid, frame_start, timing_err, sum_valid, locked} !== 5'd0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 00000",
                         {pix_valid, frame_start, timing_err, sum_valid, locked});
    end
    n_checks++;
    if (err_count !== 8'd0) begin
      n_fail++; $display("FAIL reset_err_count: got %0d want 0", err_count);
    end
    n_checks++;
    if (frame_sum !== 16'd0) begin
      n_fail++; $display("FAIL reset_frame_sum: got %0d want 0", frame_sum);
    end
    reset = 1'b0;
    @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_ideal_stream();
    clear_stats(); align = 1;
    drive_lines(0, V_TOTAL, -1, 0, 0);
    n_checks++;
    if (locked !== 1'b0 || rise_fs != -1) begin
      n_fail++; $display("FAIL ideal_no_lock_frame1: locked=%0d rise_fs=%0d want 0,-1", locked, rise_fs);
    end
    drive_lines(0, V_TOTAL, -1, 0, 0);
    n_checks++;
    if (rise_fs != 2) begin
      n_fail++; $display("FAIL ideal_lock_edge: got vsync edge %0d want 2", rise_fs);
    end
    n_checks++;
    if (pv_cnt != 2 * WIDTH * HEIGHT) begin
      n_fail++; $display("FAIL ideal_pix_count: got %0d want %0d", pv_cnt, 2 * WIDTH * HEIGHT);
    end
    n_checks++;
    if (first_x != 0 || first_y != 0) begin
      n_fail++; $display("FAIL ideal_first_pixel: got (%0d,%0d) want (0,0)", first_x, first_y);
    end
    n_checks++;
    if (last_x != 7 || last_y != 3) begin
      n_fail++; $display("FAIL ideal_last_pixel: got (%0d,%0d) want (7,3)", last_x, last_y);
    end
    n_checks++;
    if (pv_bad != 0 || xy_bad != 0) begin
      n_fail++; $display("FAIL ideal_pixel_map: got pv_bad=%0d xy_bad=%0d want 0,0", pv_bad, xy_bad);
    end
    drive_lines(0, V_TOTAL, -1, 0, 0);
    n_checks++;
    if (sv_cnt != 1 || fs_at_sv != 3) begin
      n_fail++; $display("FAIL ideal_sum_valid: got count=%0d at edge %0d want 1 at 3", sv_cnt, fs_at_sv);
    end
    n_checks++;
    if (frame_sum !== 16'd480) begin
      n_fail++; $display("FAIL ideal_frame_sum: got %0d want 480", frame_sum);
    end
    n_checks++;
    if (terr_cnt != 0 || locked !== 1'b1) begin
      n_fail++; $display("FAIL ideal_steady: terr=%0d locked=%0d want 0,1", terr_cnt, locked);
    end
    $display("test_ideal_stream done: %0d pixels, frame_sum=%0d", pv_cnt, frame_sum);
  endtask

  task automatic test_pattern();
    clear_stats(); align = 1;
    drive_lines(0, V_TOTAL, -1, 0, 1);
    drive_lines(0, V_TOTAL, -1, 0, 2);
    n_checks++;
    if (frame_sum !== 16'd112) begin
      n_fail++; $display("FAIL pattern_x_sum: got %0d want 112", frame_sum);
    end
    drive_lines(0, V_TOTAL, -1, 0, 0);
    n_checks++;
    if (frame_sum !== 16'd65504) begin
      n_fail++; $display("FAIL pattern_wrap_sum: got %0d want 65504", frame_sum);
    end
    n_checks++;
    if (rgb_bad != 0 || early_bad != 0) begin
      n_fail++; $display("FAIL pattern_rgb_latency: got rgb_bad=%0d early=%0d want 0,0", rgb_bad, early_bad);
    end
    n_checks++;
    if (pv_bad != 0 || xy_bad != 0 || sv_cnt != 3) begin
      n_fail++; $display("FAIL pattern_stream: got pv_bad=%0d xy_bad=%0d sv=%0d want 0,0,3", pv_bad, xy_bad, sv_cnt);
    end
    $display("test_pattern done: frame_sum=%0d", frame_sum);
  endtask

  task automatic test_short_line();
    clear_stats(); align = 1;
    drive_lines(0, V_TOTAL, 3, H_TOTAL - 1, 0);
    n_checks++;
    if (terr_cnt != 1 || terr_line != 4 || terr_t != 0) begin
      n_fail++; $display("FAIL short_line_err: got count=%0d at line %0d tick %0d want 1 at 4/0",
                         terr_cnt, terr_line, terr_t);
    end
    n_checks++;
    if (err_count !== 8'd1 || locked !== 1'b0) begin
      n_fail++; $display("FAIL short_line_state: got err_count=%0d locked=%0d want 1,0", err_count, locked);
    end
    drive_lines(0, V_TOTAL, -1, 0, 0);
    drive_lines(0, V_TOTAL, -1, 0, 0);
    n_checks++;
    if (rise_fs != 3 || locked !== 1'b1) begin
      n_fail++; $display("FAIL short_line_relock: got edge %0d locked=%0d want 3,1", rise_fs, locked);
    end
    n_checks++;
    if (sv_cnt != 1 || fs_at_sv != 1 || terr_cnt != 1) begin
      n_fail++; $display("FAIL short_line_sums: got sv=%0d at %0d terr=%0d want 1 at 1, 1",
                         sv_cnt, fs_at_sv, terr_cnt);
    end
    $display("test_short_line done: err_count=%0d", err_count);
  endtask

  task automatic test_short_frame();
    clear_stats(); align = 1;
    drive_lines(0, V_TOTAL - 1, -1, 0, 0);
    drive_lines(0, V_TOTAL, -1, 0, 0);
    drive_lines(0, V_TOTAL, -1, 0, 0);
    n_checks++;
    if (terr_cnt != 1 || terr_fs != 2) begin
      n_fail++; $display("FAIL short_frame_err: got count=%0d at edge %0d want 1 at 2", terr_cnt, terr_fs);
    end
    n_checks++;
    if (sv_cnt != 1 || fs_at_sv != 1) begin
      n_fail++; $display("FAIL short_frame_no_sum: got sv=%0d at edge %0d want 1 at 1", sv_cnt, fs_at_sv);
    end
    n_checks++;
    if (locked !== 1'b0 || err_count !== 8'd2) begin
      n_fail++; $display("FAIL short_frame_state: got locked=%0d err_count=%0d want 0,2", locked, err_count);
    end
    drive_lines(0, V_TOTAL, -1, 0, 0);
    n_checks++;
    if (rise_fs != 4 || locked !== 1'b1) begin
      n_fail++; $display("FAIL short_frame_relock: got edge %0d locked=%0d want 4,1", rise_fs, locked);
    end
    $display("test_short_frame done: err_count=%0d", err_count);
  endtask

  task automatic test_reset_midframe();
    clear_stats(); align = 1;
    drive_lines(0, 4, -1, 0, 0);
    n_checks++;
    if (locked !== 1'b1 || x !== 10'd7 || y !== 9'd1) begin
      n_fail++; $display("FAIL midreset_pre: got locked=%0d x=%0d y=%0d want 1,7,1", locked, x, y);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (locked !== 1'b0 || err_count !== 8'd0 || frame_sum !== 16'd0) begin
      n_fail++; $display("FAIL midreset_async: got locked=%0d err_count=%0d frame_sum=%0d want 0,0,0",
                         locked, err_count, frame_sum);
    end
    n_checks++;
    if ({x, y, rgb_out} !== 31'd0) begin
      n_fail++; $display("FAIL midreset_async_xy: got x=%0d y=%0d rgb=%h want 0", x, y, rgb_out);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    clear_stats(); align = 0;
    drive_lines(4, V_TOTAL, -1, 0, 0);
    drive_lines(0, V_TOTAL, -1, 0, 0);
    n_checks++;
    if (locked !== 1'b0) begin
      n_fail++; $display("FAIL midreset_early_lock: got locked=%0d want 0", locked);
    end
    drive_lines(0, V_TOTAL, -1, 0, 0);
    n_checks++;
    if (rise_fs != 2 || terr_cnt != 0) begin
      n_fail++; $display("FAIL midreset_relock: got edge %0d terr=%0d want 2,0", rise_fs, terr_cnt);
    end
    $display("test_reset_midframe done: locked=%0d", locked);
  endtask

  // Each 4-tick line carries both syncs, so the FSM alternates TRACK/SEARCH and
  // every second line is a (combined line+frame) mismatch.
  task automatic test_err_saturation();
    reset = 1'b1; hSync = 1'b1; vSync = 1'b1; pix_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    prev_err = 0;
    clear_stats(); align = 1;
    for (int i = 0; i < 600; i++) begin
      for (int t = 0; t < 4; t++)
        tick(t < 2, t < 2, 12'h000, 0, i, t);
      if (i == 507) begin
        n_checks++;
        if (err_count !== 8'd254) begin
          n_fail++; $display("FAIL sat_before: got %0d want 254", err_count);
        end
      end
      if (i == 509) begin
        n_checks++;
        if (err_count !== 8'd255) begin
          n_fail++; $display("FAIL sat_reach: got %0d want 255", err_count);
        end
      end
    end
    n_checks++;
    if (err_count !== 8'd255 || wrap_seen != 0) begin
      n_fail++; $display("FAIL sat_hold: got err_count=%0d wraps=%0d want 255,0", err_count, wrap_seen);
    end
    n_checks++;
    if (terr_cnt != 300 || locked !== 1'b0) begin
      n_fail++; $display("FAIL sat_pulses: got terr=%0d locked=%0d want 300,0", terr_cnt, locked);
    end
    $display("test_err_saturation done: err_count=%0d pulses=%0d", err_count, terr_cnt);
  endtask

  initial begin
    clear_stats();
    align = 1;
    test_reset();
    test_ideal_stream();
    test_pattern();
    test_short_line();
    test_short_frame();
    test_reset_midframe();
    test_err_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
